// File: rtl/mdu_ctrl_if.sv
// Issue, HI/LO move and read-back signals between the E-stage control unit
// and the multiply/divide sequencer.
interface mdu_ctrl_if;
    logic        start;
    logic [3:0]  HILOop;
    logic [1:0]  writeHL;
    logic [1:0]  readHL;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hilo_rdata;

    modport master (
        output start, HILOop, writeHL, readHL, rs_data, rt_data,
        input  busy, hi, lo, hilo_rdata
    );

    modport slave (
        input  start, HILOop, writeHL, readHL, rs_data, rt_data,
        output busy, hi, lo, hilo_rdata
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Fixed-latency multiply/divide sequencer owning HI/LO; results are computed
// from the operands latched at issue and committed on the final busy cycle.
module mdu_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        op_a_q;
    logic [31:0]        op_b_q;
    logic               signed_q;
    logic               busy_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;

    logic [63:0]        ext_a;
    logic [63:0]        ext_b;
    logic [63:0]        prod_d;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic [31:0]        uquot;
    logic [31:0]        urem;
    logic [31:0]        quot_d;
    logic [31:0]        rem_d;
    logic               div_zero;
    logic               is_mul_op;
    logic               is_div_op;

    assign is_mul_op = (bus.HILOop == 4'd1) || (bus.HILOop == 4'd2);
    assign is_div_op = (bus.HILOop == 4'd3) || (bus.HILOop == 4'd4);

    // Sign-extending to 64 bits lets one unsigned multiplier serve both flavours.
    always_comb begin
        ext_a  = {{32{signed_q & op_a_q[31]}}, op_a_q};
        ext_b  = {{32{signed_q & op_b_q[31]}}, op_b_q};
        prod_d = ext_a * ext_b;
    end

    // Signed divide runs on magnitudes; the divisor is forced non-zero so the
    // divider never sees 0 (the result is discarded in that case anyway).
    always_comb begin
        div_zero = (op_b_q == 32'd0);
        abs_a    = (signed_q && op_a_q[31]) ? (~op_a_q + 32'd1) : op_a_q;
        abs_b    = (signed_q && op_b_q[31]) ? (~op_b_q + 32'd1) : op_b_q;
        if (div_zero) begin
            abs_b = 32'd1;
        end
        uquot  = abs_a / abs_b;
        urem   = abs_a % abs_b;
        quot_d = (signed_q && (op_a_q[31] ^ op_b_q[31])) ? (~uquot + 32'd1) : uquot;
        rem_d  = (signed_q && op_a_q[31]) ? (~urem + 32'd1) : urem;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            signed_q <= 1'b0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        // start always wins over a same-cycle mthi/mtlo
                        if (is_mul_op || is_div_op) begin
                            op_a_q   <= bus.rs_data;
                            op_b_q   <= bus.rt_data;
                            signed_q <= (bus.HILOop == 4'd1) || (bus.HILOop == 4'd3);
                            busy_q   <= 1'b1;
                            if (is_mul_op) begin
                                state_q <= RUN_MUL;
                                cnt_q   <= CNT_W'(MUL_LAT - 1);
                            end else begin
                                state_q <= RUN_DIV;
                                cnt_q   <= CNT_W'(DIV_LAT - 1);
                            end
                        end
                    end else if (bus.writeHL == 2'd1) begin
                        hi_q <= bus.rs_data;
                    end else if (bus.writeHL == 2'd2) begin
                        lo_q <= bus.rs_data;
                    end
                end
                RUN_MUL: begin
                    if (cnt_q == '0) begin
                        hi_q    <= prod_d[63:32];
                        lo_q    <= prod_d[31:0];
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RUN_DIV: begin
                    if (cnt_q == '0) begin
                        if (!div_zero) begin
                            hi_q <= rem_d;
                            lo_q <= quot_d;
                        end
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    always_comb begin
        case (bus.readHL)
            2'd1:    bus.hilo_rdata = hi_q;
            2'd2:    bus.hilo_rdata = lo_q;
            default: bus.hilo_rdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO pushed at issue, popped and
// compared when busy falls; busy length, mt/mf and reset are checked too.
module tb_mdu_ctrl;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic clk;
    logic reset;
    mdu_ctrl_if bus ();

    mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference model on 64-bit integers, independent of the DUT datapath.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      q;
        longint      r;
        logic [63:0] t;
        case (op)
            4'd1: begin t = 64'(sa * sb); hi_m = t[63:32]; lo_m = t[31:0]; end
            4'd2: begin t = {32'd0, a} * {32'd0, b}; hi_m = t[63:32]; lo_m = t[31:0]; end
            4'd3: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                t = 64'(q); lo_m = t[31:0];
                t = 64'(r); hi_m = t[31:0];
            end
            4'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
            default: ;
        endcase
    endfunction

    task automatic check_reads(input string tag);
        bus.readHL = 2'd1; #1 chk({tag, "_rdhi"}, bus.hilo_rdata, hi_m);
        bus.readHL = 2'd2; #1 chk({tag, "_rdlo"}, bus.hilo_rdata, lo_m);
        bus.readHL = 2'd0;
    endtask

    // Called at a negedge with the unit idle; returns at the first idle negedge.
    // inj_kind 1: stray start at busy cycle inj_cyc; 2: mtlo at busy cycle inj_cyc.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int inj_cyc, input int inj_kind);
        exp_t e;
        int   n;
        logic [31:0] lo_before;
        lo_before = lo_m;
        model(op, a, b);
        sb_q.push_back('{hi: hi_m, lo: lo_m});
        bus.start = 1'b1; bus.HILOop = op; bus.rs_data = a; bus.rt_data = b;
        @(negedge clk);
        bus.start = 1'b0; bus.HILOop = 4'd0;
        bus.rs_data = $urandom; bus.rt_data = $urandom;
        chk("busy_rise", {31'd0, bus.busy}, 32'd1);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            if (n == inj_cyc && inj_kind == 1) begin
                bus.start = 1'b1; bus.HILOop = 4'd1;
            end else if (n == inj_cyc && inj_kind == 2) begin
                bus.writeHL = 2'd2; bus.rs_data = 32'hDEAD;
            end
            @(negedge clk);
            bus.start = 1'b0; bus.HILOop = 4'd0; bus.writeHL = 2'd0;
            if (n == inj_cyc && inj_kind == 2) chk("busy_mtlo", bus.lo, lo_before);
        end
        chk("busy_len", n, lat);
        e = sb_q.pop_front();
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
        check_reads("op");
        $display("op=%0d a=%08h b=%08h busy=%0d hi=%08h lo=%08h", op, a, b, n, bus.hi, bus.lo);
    endtask

    task automatic write_hl(input logic [1:0] sel, input logic [31:0] val);
        bus.writeHL = sel; bus.rs_data = val;
        @(negedge clk);
        bus.writeHL = 2'd0; bus.rs_data = $urandom;
        if (sel == 2'd1) hi_m = val;
        if (sel == 2'd2) lo_m = val;
        check_reads("mt");
        $display("mt sel=%0d val=%08h hi=%08h lo=%08h", sel, val, bus.hi, bus.lo);
    endtask

    initial begin
        bus.start = 1'b0; bus.HILOop = 4'd0; bus.writeHL = 2'd0; bus.readHL = 2'd0;
        bus.rs_data = 32'd0; bus.rt_data = 32'd0;
        reset = 1'b0;
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        bus.readHL = 2'd1; #1 chk("rst_rd", bus.hilo_rdata, 32'd0); bus.readHL = 2'd0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Plan vectors, issued back-to-back in the first idle cycle each time.
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, MUL_LAT, 0, 0);
        run_op(4'd2, 32'hFFFFFFFE, 32'd3, MUL_LAT, 0, 0);
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, DIV_LAT, 0, 0);
        run_op(4'd4, 32'hFFFFFFF9, 32'd2, DIV_LAT, 0, 0);
        run_op(4'd1, 32'h00000007, 32'h00000006, MUL_LAT, 0, 0);
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, DIV_LAT, 0, 0);

        // Divide by zero leaves HI/LO; stray start and mtlo while busy are ignored.
        write_hl(2'd1, 32'h11);
        write_hl(2'd2, 32'h22);
        run_op(4'd3, 32'h12345678, 32'd0, DIV_LAT, 3, 1);
        run_op(4'd4, 32'h00000099, 32'd0, DIV_LAT, 4, 2);

        write_hl(2'd2, 32'hABCD);

        // start with an unknown op wins over the same-cycle mthi and does nothing.
        bus.start = 1'b1; bus.HILOop = 4'd7; bus.writeHL = 2'd1; bus.rs_data = 32'h5555;
        @(negedge clk);
        bus.start = 1'b0; bus.HILOop = 4'd0; bus.writeHL = 2'd0;
        chk("badop_busy", {31'd0, bus.busy}, 32'd0);
        chk("badop_hi", bus.hi, hi_m);
        $display("badop start op=7 with mthi: busy=%0b hi=%08h", bus.busy, bus.hi);

        for (int i = 0; i < 6; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(1, 4));
            a  = $urandom;
            b  = (i == 2) ? 32'hFFFFFFFF : $urandom;
            run_op(op, a, b, (op <= 4'd2) ? MUL_LAT : DIV_LAT, 0, 0);
        end

        // Asynchronous reset in the middle of a divide discards it.
        bus.start = 1'b1; bus.HILOop = 4'd3; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
        @(negedge clk);
        bus.start = 1'b0; bus.HILOop = 4'd0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);
        bus.readHL = 2'd1; #1 chk("midrst_rd", bus.hilo_rdata, 32'd0); bus.readHL = 2'd0;
        hi_m = 32'd0; lo_m = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        repeat (DIV_LAT + 2) @(negedge clk);
        chk("postrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("postrst_lo", bus.lo, 32'd0);
        $display("midrun reset: busy=%0b hi=%08h lo=%08h", bus.busy, bus.hi, bus.lo);
        run_op(4'd2, 32'h0000FFFF, 32'h00010001, MUL_LAT, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit sequencer in the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu issues from the control unit and runs them for a fixed latency.
- Owns the HI/LO registers, services mthi/mtlo writes and mfhi/mflo reads.
- Drives `busy` back to the control unit's stall logic.

Parameters:
- MUL_LAT, 5: busy cycles for mult/multu (must be ≥1).
- DIV_LAT, 10: busy cycles for div/divu (must be ≥1).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  issue pulse for a mult/div op, driven from the E-stage start_o.
- HILOop  in  4  op select: 1=MULT, 2=MULTU, 3=DIV, 4=DIVU; other values = none.
- writeHL  in  2  1=mthi, 2=mtlo, 0/3=no write.
- readHL  in  2  1=read HI, 2=read LO, 0/3=none.
- rs_data  in  32  forwarded rs operand (dividend / multiplicand / mt source).
- rt_data  in  32  forwarded rt operand (divisor / multiplier).
- busy  out  1  high while an op is in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.
- hilo_rdata  out  32  mf read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, busy=0, hi=0, lo=0, counter=0.
  - Any in-flight op is discarded; HI/LO are not updated by it.
- States:
  - IDLE.
  - RUN_MUL.
  - RUN_DIV.
- IDLE → RUN_MUL: at the edge ending cycle T, when start=1 and HILOop ∈ {1,2}.
  - Latch rs_data and rt_data.
  - Latch the signed/unsigned flag.
  - Load counter=MUL_LAT-1.
- IDLE → RUN_DIV: same rule for HILOop ∈ {3,4}, with counter=DIV_LAT-1.
- start=1 with any other HILOop: ignored; state stays IDLE.
- busy is high during cycles T+1 … T+LAT inclusive.
- RUN_*: counter decrements each edge. At the edge where counter==0:
  - Commit the result to hi/lo.
  - Return to IDLE.
  - busy=0 from cycle T+LAT+1.
- Back-to-back issue: a new start is accepted in the first IDLE cycle after completion.
- Arithmetic, all on latched operands:
  - MULT: 64-bit signed product; hi=[63:32], lo=[31:0].
  - MULTU: same as MULT, but the 64-bit product is unsigned.
  - DIV: signed; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned; lo=quotient, hi=remainder.
  - Divisor==0: the op still runs its full DIV_LAT; hi/lo remain unchanged at completion.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo:
  - Accepted only in IDLE with start=0.
  - writeHL=1 loads hi←rs_data; writeHL=2 loads lo←rs_data, at the next edge.
  - Ignored while busy or when start=1 in the same cycle (start wins).
- start while busy: ignored. No queueing; the in-flight op is unaffected. The control unit stalls in this case, so this is defensive only.
- hilo_rdata (combinational): readHL=1 → hi, readHL=2 → lo, else 0.
  - Reflects committed values only; the control unit guarantees no mf is issued while busy or start.
- Operands are sampled only at issue. Later changes on rs_data/rt_data do not affect the result.

Test Plan:
- Reset, then read: reset low mid-run → busy=0, hi=lo=0 immediately; readHL=1 → hilo_rdata=0.
- MULT: start, HILOop=1, rs=0xFFFFFFFE (-2), rt=3 at cycle T.
  - busy=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU: same operands, HILOop=2 → hi=0x00000002, lo=0xFFFFFFFA.
- DIV/DIVU: HILOop=3, rs=-7, rt=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Same operands with HILOop=4 → lo=0x7FFFFFFC, hi=0x00000001.
- Divide by zero, then start while busy:
  - Preload hi=0x11, lo=0x22 via mthi/mtlo, then DIV with rt=0 → busy 10 cycles, hi=0x11, lo=0x22 unchanged.
  - A second start at busy cycle 3 is ignored.
- mt/mf timing and back-to-back ops:
  - mtlo rs=0xABCD in IDLE → next cycle readHL=2 gives 0xABCD.
  - mtlo during busy → lo not overwritten.
  - MULT issued the first cycle after busy falls → accepted, busy re-asserts the next cycle.
